// File: rtl/solver_dispatch.sv
// rtl/solver_dispatch.sv - host task queue, credit-gated issue to a multi-context solver, result queue.
// Dummy terminal boards are driven whenever no real task may be issued, so the solver never stalls.
module solver_dispatch #(
  parameter int TASK_DEPTH = 8,
  parameter int RES_DEPTH  = 16,
  parameter int NCTX       = 16
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iTaskValid,
  output logic        oTaskReady,
  input  logic [63:0] iTaskPlayer,
  input  logic [63:0] iTaskOpponent,
  input  logic [7:0]  iTaskTag,
  output logic [63:0] oSolvPlayer,
  output logic [63:0] oSolvOpponent,
  input  logic        iSolvTake,
  input  logic        iSolvSolved,
  input  logic [3:0]  iSolvCtx,
  input  logic [7:0]  iSolvRes,
  output logic        oResValid,
  input  logic        iResReady,
  output logic [7:0]  oResTag,
  output logic [7:0]  oResScore,
  output logic [4:0]  oInFlight
);

  localparam int TP_W  = (TASK_DEPTH > 1) ? $clog2(TASK_DEPTH) : 1;
  localparam int TC_W  = $clog2(TASK_DEPTH + 1);
  localparam int RP_W  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int RC_W  = $clog2(RES_DEPTH + 1);
  localparam int CTX_W = (NCTX > 1) ? $clog2(NCTX) : 1;

  localparam logic [63:0] DUMMY_PLAYER   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DUMMY_OPPONENT = 64'h0;

  logic [63:0]     task_player_mem [TASK_DEPTH];
  logic [63:0]     task_opp_mem    [TASK_DEPTH];
  logic [7:0]      task_tag_mem    [TASK_DEPTH];
  logic [TP_W-1:0] task_wr_q, task_rd_q;
  logic [TC_W-1:0] task_cnt_q, task_cnt_d;

  logic [15:0]     res_mem [RES_DEPTH];
  logic [RP_W-1:0] res_wr_q, res_rd_q;
  logic [RC_W-1:0] res_cnt_q, res_cnt_d;

  logic [NCTX-1:0] tag_valid_q;
  logic [7:0]      tag_val_q [NCTX];

  logic [4:0]      inflight_q, inflight_d;
  logic            ready_q;

  logic            task_push, task_pop, task_nonempty;
  logic            res_push, res_pop, res_nonempty;
  logic            issue_en, solved_hit;
  logic [6:0]      occupancy;
  logic [CTX_W-1:0] ctx;

  assign ctx           = iSolvCtx[CTX_W-1:0];
  assign task_nonempty = (task_cnt_q != '0);
  assign res_nonempty  = (res_cnt_q != '0);
  assign oTaskReady    = ready_q && (task_cnt_q < TC_W'(TASK_DEPTH));

  // Credits come from registered occupancy only, so a same-cycle result push cannot unlock an issue.
  assign occupancy = 7'(res_cnt_q) + 7'(inflight_q);
  assign issue_en  = task_nonempty && (occupancy < 7'(RES_DEPTH));

  assign task_push  = iTaskValid && oTaskReady;
  assign task_pop   = iSolvTake && issue_en;
  assign solved_hit = iSolvSolved && tag_valid_q[ctx];
  assign res_push   = solved_hit;
  assign res_pop    = res_nonempty && iResReady;

  assign oSolvPlayer   = issue_en ? task_player_mem[task_rd_q] : DUMMY_PLAYER;
  assign oSolvOpponent = issue_en ? task_opp_mem[task_rd_q]    : DUMMY_OPPONENT;

  assign oResValid = res_nonempty;
  assign oResTag   = res_nonempty ? res_mem[res_rd_q][15:8] : 8'h00;
  assign oResScore = res_nonempty ? res_mem[res_rd_q][7:0]  : 8'h00;
  assign oInFlight = inflight_q;

  always_comb begin
    task_cnt_d = task_cnt_q + TC_W'(task_push) - TC_W'(task_pop);
    res_cnt_d  = res_cnt_q + RC_W'(res_push) - RC_W'(res_pop);
    inflight_d = inflight_q + 5'(task_pop) - 5'(solved_hit);
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ready_q     <= 1'b0;
      task_wr_q   <= '0;
      task_rd_q   <= '0;
      task_cnt_q  <= '0;
      res_wr_q    <= '0;
      res_rd_q    <= '0;
      res_cnt_q   <= '0;
      inflight_q  <= '0;
      tag_valid_q <= '0;
    end else begin
      ready_q    <= 1'b1;
      task_cnt_q <= task_cnt_d;
      res_cnt_q  <= res_cnt_d;
      inflight_q <= inflight_d;
      if (task_push)
        task_wr_q <= (task_wr_q == TP_W'(TASK_DEPTH - 1)) ? '0 : task_wr_q + 1'b1;
      if (task_pop)
        task_rd_q <= (task_rd_q == TP_W'(TASK_DEPTH - 1)) ? '0 : task_rd_q + 1'b1;
      if (res_push)
        res_wr_q <= (res_wr_q == RP_W'(RES_DEPTH - 1)) ? '0 : res_wr_q + 1'b1;
      if (res_pop)
        res_rd_q <= (res_rd_q == RP_W'(RES_DEPTH - 1)) ? '0 : res_rd_q + 1'b1;
      // A take on the same context overrides the solved clear; the result already used the old entry.
      if (solved_hit)
        tag_valid_q[ctx] <= 1'b0;
      if (iSolvTake)
        tag_valid_q[ctx] <= task_pop;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (task_push) begin
      task_player_mem[task_wr_q] <= iTaskPlayer;
      task_opp_mem[task_wr_q]    <= iTaskOpponent;
      task_tag_mem[task_wr_q]    <= iTaskTag;
    end
    if (res_push)
      res_mem[res_wr_q] <= {tag_val_q[ctx], iSolvRes};
    if (task_pop)
      tag_val_q[ctx] <= task_tag_mem[task_rd_q];
  end

  always @(posedge iCLOCK) begin
    if (inRESET)
      assert (!(res_push && (res_cnt_q == RC_W'(RES_DEPTH))));
  end

endmodule

// File: tb/tb_solver_dispatch.sv
// tb/tb_solver_dispatch.sv - directed self-checking bench for solver_dispatch.
module tb_solver_dispatch;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iTaskValid;
  logic        oTaskReady;
  logic [63:0] iTaskPlayer;
  logic [63:0] iTaskOpponent;
  logic [7:0]  iTaskTag;
  logic [63:0] oSolvPlayer;
  logic [63:0] oSolvOpponent;
  logic        iSolvTake;
  logic        iSolvSolved;
  logic [3:0]  iSolvCtx;
  logic [7:0]  iSolvRes;
  logic        oResValid;
  logic        iResReady;
  logic [7:0]  oResTag;
  logic [7:0]  oResScore;
  logic [4:0]  oInFlight;

  solver_dispatch #(.TASK_DEPTH(8), .RES_DEPTH(16), .NCTX(16)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iTaskValid(iTaskValid), .oTaskReady(oTaskReady),
    .iTaskPlayer(iTaskPlayer), .iTaskOpponent(iTaskOpponent), .iTaskTag(iTaskTag),
    .oSolvPlayer(oSolvPlayer), .oSolvOpponent(oSolvOpponent),
    .iSolvTake(iSolvTake), .iSolvSolved(iSolvSolved), .iSolvCtx(iSolvCtx), .iSolvRes(iSolvRes),
    .oResValid(oResValid), .iResReady(iResReady), .oResTag(oResTag), .oResScore(oResScore),
    .oInFlight(oInFlight)
  );

  always #5 iCLOCK = ~iCLOCK;

  localparam logic [63:0] DUMMY_P = 64'hFFFF_FFFF_FFFF_FFFF;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pboard(input logic [7:0] t);
    return {32'hA5A5_0000, 24'h0, t};
  endfunction

  function automatic logic [63:0] oboard(input logic [7:0] t);
    return {32'h0000_5A5A, 24'h0, ~t};
  endfunction

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic idle();
    iTaskValid = 1'b0; iTaskTag = 8'h0; iTaskPlayer = 64'h0; iTaskOpponent = 64'h0;
    iSolvTake = 1'b0; iSolvSolved = 1'b0; iSolvCtx = 4'h0; iSolvRes = 8'h0; iResReady = 1'b0;
  endtask

  task automatic offer(input logic [7:0] t);
    iTaskValid = 1'b1; iTaskTag = t; iTaskPlayer = pboard(t); iTaskOpponent = oboard(t);
  endtask

  logic [7:0]  mq[$];
  logic [15:0] expq[$];
  logic        m_valid [16];
  logic [7:0]  m_tag [16];
  int          m_res, m_inflight, pushed, dut_issues;
  logic        en;
  int          size0;
  logic [3:0]  cx;
  logic [15:0] er;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    inRESET = 1'b0;
    idle();
    #12;
    check("rst_ready", oTaskReady, 0);
    check("rst_resvalid", oResValid, 0);
    check("rst_inflight", oInFlight, 0);
    check("rst_restag", oResTag, 0);
    check("rst_resscore", oResScore, 0);
    check("rst_dummy_p", oSolvPlayer, DUMMY_P);
    #4 inRESET = 1'b1;
    #1 check("rst_ready_before_edge", oTaskReady, 0);
    tick();
    check("rst_ready_after_edge", oTaskReady, 1);

    // single task round trip
    offer(8'h2A); tick(); idle();
    check("t1_head_p", oSolvPlayer, pboard(8'h2A));
    check("t1_head_o", oSolvOpponent, oboard(8'h2A));
    iSolvTake = 1; iSolvCtx = 4'd3; tick(); idle();
    check("t1_inflight1", oInFlight, 1);
    check("t1_dummy_after", oSolvPlayer, DUMMY_P);
    iSolvSolved = 1; iSolvCtx = 4'd3; iSolvRes = 8'sd12; tick(); idle();
    check("t1_inflight0", oInFlight, 0);
    check("t1_resvalid", oResValid, 1);
    check("t1_restag", oResTag, 8'h2A);
    check("t1_resscore", oResScore, 8'h0C);
    iResReady = 1; tick(); idle();
    check("t1_popped", oResValid, 0);

    // dummy issue on empty queue, its completion discarded
    iSolvTake = 1; iSolvCtx = 4'd5;
    check("t2_dummy_p", oSolvPlayer, DUMMY_P);
    check("t2_dummy_o", oSolvOpponent, 64'h0);
    tick(); idle();
    check("t2_inflight", oInFlight, 0);
    iSolvSolved = 1; iSolvCtx = 4'd5; iSolvRes = 8'hC0; tick(); idle();
    check("t2_noresult", oResValid, 0);
    check("t2_inflight_after", oInFlight, 0);

    // same-cycle solved + take on one context
    offer(8'h01); tick(); idle();
    iSolvTake = 1; iSolvCtx = 4'd7; tick(); idle();
    offer(8'h02); tick(); idle();
    check("t3_inflight_pre", oInFlight, 1);
    check("t3_head", oSolvPlayer, pboard(8'h02));
    iSolvTake = 1; iSolvSolved = 1; iSolvCtx = 4'd7; iSolvRes = 8'h05; tick(); idle();
    check("t3_inflight_same", oInFlight, 1);
    check("t3_restag_old", oResTag, 8'h01);
    check("t3_resscore", oResScore, 8'h05);
    iResReady = 1; tick(); idle();
    check("t3_popped", oResValid, 0);
    iSolvSolved = 1; iSolvCtx = 4'd7; iSolvRes = 8'h09; tick(); idle();
    check("t3_restag_new", oResTag, 8'h02);
    check("t3_resscore_new", oResScore, 8'h09);
    check("t3_inflight_end", oInFlight, 0);
    iResReady = 1; tick(); idle();

    // task queue full handling
    for (int i = 0; i < 8; i++) begin
      offer(8'h10 + 8'(i));
      check($sformatf("t4_ready_%0d", i), oTaskReady, 1);
      tick();
    end
    offer(8'h18);
    check("t4_full", oTaskReady, 0);
    tick();
    check("t4_held", oTaskReady, 0);
    iSolvTake = 1; iSolvCtx = 4'd0;
    check("t4_head_order", oSolvPlayer, pboard(8'h10));
    tick();
    check("t4_ready_back", oTaskReady, 1);
    iSolvTake = 0; tick(); idle();
    for (int i = 1; i <= 8; i++) begin
      iSolvTake = 1; iSolvCtx = 4'(i);
      if (i == 8) check("t4_ninth_head", oSolvPlayer, pboard(8'h18));
      tick(); idle();
    end
    check("t4_inflight9", oInFlight, 9);

    // asynchronous reset with work in flight
    #2 inRESET = 1'b0;
    #1;
    check("t5_inflight", oInFlight, 0);
    check("t5_ready", oTaskReady, 0);
    check("t5_resvalid", oResValid, 0);
    check("t5_dummy", oSolvPlayer, DUMMY_P);
    #2 inRESET = 1'b1;
    tick();
    check("t5_ready_back", oTaskReady, 1);
    for (int i = 0; i <= 8; i++) begin
      iSolvSolved = 1; iSolvCtx = 4'(i); iSolvRes = 8'h33; tick(); idle();
    end
    check("t5_noresults", oResValid, 0);
    check("t5_inflight_end", oInFlight, 0);

    // credit exhaustion with result queue blocked
    m_res = 0; m_inflight = 0; pushed = 0; dut_issues = 0;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_tag[i] = 8'h0; end
    for (int c = 0; c < 40; c++) begin
      idle();
      if (pushed < 20) offer(8'h40 + 8'(pushed));
      iSolvTake = 1; iSolvSolved = (c > 0); cx = 4'(c % 16); iSolvCtx = cx; iSolvRes = 8'(c * 3);
      size0 = mq.size();
      en = (size0 > 0) && (m_res + m_inflight < 16);
      check($sformatf("t6_ready_c%0d", c), oTaskReady, (size0 < 8));
      check($sformatf("t6_board_c%0d", c), oSolvPlayer, en ? pboard(mq[0]) : DUMMY_P);
      if (oSolvPlayer !== DUMMY_P) dut_issues++;
      if (iSolvSolved && m_valid[cx]) begin
        expq.push_back({m_tag[cx], iSolvRes});
        m_res++; m_inflight--; m_valid[cx] = 0;
      end
      if (en) begin
        m_valid[cx] = 1; m_tag[cx] = mq.pop_front(); m_inflight++;
      end else begin
        m_valid[cx] = 0;
      end
      if (iTaskValid && size0 < 8) begin mq.push_back(iTaskTag); pushed++; end
      tick();
    end
    idle();
    check("t6_real_issues", 64'(dut_issues), 16);
    check("t6_inflight", oInFlight, 0);
    check("t6_resvalid", oResValid, 1);
    check("t6_dummy_blocked", oSolvPlayer, DUMMY_P);
    iResReady = 1;
    for (int k = 0; k < 16; k++) begin
      er = (expq.size() > 0) ? expq.pop_front() : 16'hDEAD;
      check($sformatf("t6_res%0d", k), {oResValid, oResTag, oResScore}, {1'b1, er});
      tick();
    end
    idle();
    check("t6_drained", oResValid, 0);
    iSolvTake = 1; iSolvCtx = 4'd0;
    check("t6_resume_board", oSolvPlayer, pboard(8'h50));
    tick(); idle();
    check("t6_resume_inflight", oInFlight, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
